regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-read-port register file with write-to-read bypass, a hardwired zero register and a per-register pending-write scoreboard. It replaces the fixed 32x32, two-read-port register file in the decode stage of the pipelined MIPS core. Reads are combinational. Writes and scoreboard updates happen on the clock edge. Decode/hazard logic uses the busy outputs to stall on RAW dependencies against in-flight producers.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports

- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  reset, asynchronous and active-high
- regRdAddr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- regRdData  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
- regRdBusy  out  NUM_RD  port k's register has an outstanding reservation not resolved this cycle
- regWrEn  in  1  write enable (RegWrite from writeback)
- regWrAddr  in  ADDR_W  write address
- regWrData  in  DATA_W  write data
- rsvEn  in  1  reserve destination register at issue
- rsvAddr  in  ADDR_W  register to reserve
- pendCnt  out  ADDR_W+1  number of registers currently reserved

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits and a pend bit vector of 2**ADDR_W bits.
- A write occurs when regWrEn=1. It is suppressed when ZERO_REG=1 and regWrAddr=0.
- A reservation occurs when rsvEn=1. It is suppressed when ZERO_REG=1 and rsvAddr=0.
- Read port k, evaluated in this order:
  - ZERO_REG=1 and address 0 -> 0.
  - BYPASS=1, write occurring and regWrAddr equals the port address -> regWrData.
  - Otherwise -> stored entry.
- Write path: the entry is updated at the edge. pend[regWrAddr] is cleared unless the same edge also reserves that address.
- Reservation path: pend[rsvAddr] is set at the edge.
  - Reserve and write to the same address in one cycle: set wins. pend stays 1, because a younger producer was issued.
  - Reserving an already-pending register: no change, and pendCnt does not change.
  - A write to an unreserved register is legal. It updates data and leaves pend 0.
- regRdBusy[k] = pend[addr_k] AND NOT (BYPASS=1 AND write occurring to addr_k). It is forced to 0 for address 0 when ZERO_REG=1.
- With BYPASS=0, busy stays 1 through the write cycle and drops the cycle after.
- pendCnt is a registered counter, updated incrementally, never recomputed by popcount:
  - +1 when a reservation sets a clear bit.
  - -1 when a write clears a set bit.
  - Net 0 when both happen on different addresses, or when the same-address set-wins case applies.
  - It cannot exceed 2**ADDR_W-ZERO_REG.
- Multiple read ports may address the same register, and every one of them returns identical data.

## Timing
- Read latency 0: regRdData and regRdBusy are combinational from addresses, stored state and the write inputs.
- Write and reservation latency: 1 edge. Without bypass, the value is visible on reads the cycle after regWrEn.
- Reset (i_rst=1):
  - Asynchronously clears all entries, all pend bits and pendCnt to 0.
  - All regRdData = 0 and all regRdBusy = 0 from assertion, with no clock required.
  - Bypass is suppressed while i_rst=1.
  - Writes and reservations presented while i_rst=1 are dropped.
- Reset deasserted mid-sequence: the first edge after deassertion performs normal updates.
- No internal FSM beyond the pend/pendCnt state. No backpressure: every request is accepted in its cycle.

## Test plan
- Reset: load r5=0xDEADBEEF, reserve r7, assert i_rst between edges -> r5 reads 0 immediately, regRdBusy=0, pendCnt=0; after release r5 still reads 0.
- Zero register: write 0x12345678 to r0 and reserve r0 -> all ports read r0 as 0, busy 0, pendCnt unchanged (ZERO_REG=1).
- Bypass:
  - BYPASS=1: regWrEn=1 to r3 with 0xA5A5A5A5 while port 1 reads r3 -> port 1 shows 0xA5A5A5A5 in the same cycle.
  - BYPASS=0: same stimulus -> port 1 shows the old value, and the new value the next cycle.
- Scoreboard:
  - Reserve r9 -> next cycle busy=1 on a port reading r9, pendCnt=1.
  - Write r9 -> busy=0 in the write cycle (BYPASS=1), pendCnt=0 after the edge.
- Simultaneous events:
  - Same cycle: reserve r4 and write r4 while r4 is pending -> pend stays 1, pendCnt unchanged.
  - Same cycle: reserve r6 and write pending r4 -> pendCnt unchanged, r6 busy, r4 not busy.
- Multi-port/parameter sweep:
  - NUM_RD=4, DATA_W=64, ADDR_W=4: write distinct patterns to all 16 entries, read with all ports on the same and different addresses -> matches a reference model.
  - Reserve all 15 non-zero registers -> pendCnt=15.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb
//
// Parametrised register file with combinational multi-port reads, optional
// write-to-read bypass, an optional hardwired zero register and a
// per-register pending-write scoreboard. Decode logic uses the busy outputs
// to stall on RAW hazards against producers that are still in flight.
//
// Ports
//   i_clk      : clock, all state updates on the rising edge
//   i_rst      : asynchronous active-high reset
//   regRdAddr  : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   regRdData  : packed read data, port k at [k*DATA_W +: DATA_W]
//   regRdBusy  : per-port "register has an unresolved reservation"
//   regWrEn    : write enable from writeback
//   regWrAddr  : write address
//   regWrData  : write data
//   rsvEn      : reserve a destination register at issue
//   rsvAddr    : register to reserve
//   pendCnt    : number of registers currently reserved

module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_RD*ADDR_W-1:0] regRdAddr,
    output logic [NUM_RD*DATA_W-1:0] regRdData,
    output logic [NUM_RD-1:0]        regRdBusy,
    input  logic                     regWrEn,
    input  logic [ADDR_W-1:0]        regWrAddr,
    input  logic [DATA_W-1:0]        regWrData,
    input  logic                     rsvEn,
    input  logic [ADDR_W-1:0]        rsvAddr,
    output logic [ADDR_W:0]          pendCnt
);

    localparam int DEPTH    = 1 << ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;

    logic              wr_fire;
    logic              rsv_fire;
    logic              pend_set;
    logic              pend_clr;
    logic [ADDR_W-1:0] rd_addr;

    // Qualified requests. Anything presented during reset is dropped, which
    // also keeps the bypass path quiet while i_rst is high.
    always_comb begin
        wr_fire  = regWrEn && !i_rst && !(HAS_ZERO && (regWrAddr == '0));
        rsv_fire = rsvEn   && !i_rst && !(HAS_ZERO && (rsvAddr   == '0));
    end

    // Next-state for storage, pend bits and the reservation counter.
    // The reservation is applied after the write clear so that a same-address
    // reserve+write leaves the bit set: the reservation belongs to a younger
    // producer than the one now writing back.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_fire) begin
            mem_d[regWrAddr]  = regWrData;
            pend_d[regWrAddr] = 1'b0;
        end
        if (rsv_fire) begin
            pend_d[rsvAddr] = 1'b1;
        end

        pend_set = rsv_fire && !pend_q[rsvAddr];
        pend_clr = wr_fire && pend_q[regWrAddr] &&
                   !(rsv_fire && (rsvAddr == regWrAddr));
        cnt_d    = cnt_q + (ADDR_W+1)'(pend_set) - (ADDR_W+1)'(pend_clr);
    end

    // State registers with asynchronous clear of data, pend bits and count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports. Priority: zero register, then bypass of the in-flight
    // write, then stored entry. A bypassed write also resolves busy.
    always_comb begin
        regRdData = '0;
        regRdBusy = '0;
        rd_addr   = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr = regRdAddr[k*ADDR_W +: ADDR_W];
            if (HAS_ZERO && (rd_addr == '0)) begin
                regRdData[k*DATA_W +: DATA_W] = '0;
                regRdBusy[k]                  = 1'b0;
            end else if (HAS_BYP && wr_fire && (regWrAddr == rd_addr)) begin
                regRdData[k*DATA_W +: DATA_W] = regWrData;
                regRdBusy[k]                  = 1'b0;
            end else begin
                regRdData[k*DATA_W +: DATA_W] = mem_q[rd_addr];
                regRdBusy[k]                  = pend_q[rd_addr];
            end
        end
    end

    assign pendCnt = cnt_q;

endmodule
